// File: rtl/pwl_coeff_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwl_coeff_loader_pkg
// Description : Shared definitions for the PWL coefficient table loader.
//               Holds the fixed-point format of the coefficients, the table
//               geometry, the packed coefficient word and the loader states.
// Revision    : 1.0  initial release
// ============================================================================
package pwl_coeff_loader_pkg;

    localparam int DATA_WIDTH = 16;   // Q3.12 coefficient width
    localparam int FRAC_BITS  = 12;
    localparam int PWL_DEPTH  = 64;   // table entries, power of two
    localparam int PWL_ADDR_W = 6;    // log2(PWL_DEPTH)

    // Packed stream/table word: slope in the upper half, intercept below.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] slope;
        logic [DATA_WIDTH-1:0] intercept;
    } pwl_coeff_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } pwl_ld_state_t;

endpackage : pwl_coeff_loader_pkg
`default_nettype wire

// File: rtl/pwl_coeff_ram.sv
`default_nettype none
// ============================================================================
// Module      : pwl_coeff_ram
// Description : 1-write / 1-read synchronous RAM for the PWL coefficient
//               table. Registered read with read-before-write behaviour: a
//               read of the address being written returns the old contents.
//               Only the read register is reset; the array is not.
// Ports       : clk, rst_n       clock, async active-low reset (read reg)
//               i_we, i_wr_addr, i_wr_data   write port
//               i_rd_addr, o_rd_data         registered read port
// Revision    : 1.0  initial release
// ============================================================================
module pwl_coeff_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WORD_W-1:0] o_rd_data
);

    (* ram_style = "distributed" *)
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Non-blocking update of r_mem makes this sample the pre-write value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : pwl_coeff_ram
`default_nettype wire

// File: rtl/pwl_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : pwl_coeff_loader
// Description : Writer side of the PWL activation coefficient tables. Accepts
//               a valid/ready stream of {slope, intercept} words, writes them
//               in address order into a DEPTH-entry table and exposes the
//               registered read port used by the PWL evaluator.
// Config      : PWL_CHECKSUM_EN - when defined, each load carries one extra
//               word after the coefficients that must equal their XOR.
// Ports       : clk, rst_n                  clock, async active-low reset
//               start                       pulse, begins a load (IDLE only)
//               s_valid/s_ready/s_data/s_last   coefficient stream
//               table_valid                 table holds an accepted load
//               load_done                   1-cycle pulse on good completion
//               load_err                    sticky error, cleared by start
//               rd_addr/rd_data             evaluator read port (1 cycle)
// Revision    : 1.0  initial release
// ============================================================================
module pwl_coeff_loader
    import pwl_coeff_loader_pkg::*;
#(
    parameter int DEPTH  = PWL_DEPTH,
    parameter int ADDR_W = PWL_ADDR_W,
    parameter int WORD_W = 2 * DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    output logic              table_valid,
    output logic              load_done,
    output logic              load_err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    pwl_ld_state_t   r_state, w_state_nxt;
    // One spare bit so the counter can index the checksum slot without wrap.
    logic [ADDR_W:0] r_cnt, w_cnt_nxt;
    logic            r_table_valid, w_table_valid_nxt;
    logic            r_load_err, w_load_err_nxt;
    logic            r_load_done, w_load_done_nxt;
    logic            w_accept;
    logic            w_final;
    logic            w_sum_ok;
    logic            w_we;

    assign w_accept = (r_state == ST_LOAD) && s_valid;

`ifdef PWL_CHECKSUM_EN
    localparam logic [ADDR_W:0] c_CNT_SUM = (ADDR_W+1)'(DEPTH);

    logic [WORD_W-1:0] r_xor, w_xor_nxt;

    // The final word is the checksum; it is compared, never stored.
    assign w_final  = (r_cnt == c_CNT_SUM);
    assign w_sum_ok = (s_data == r_xor);
    assign w_we     = w_accept && !w_final;
`else
    localparam logic [ADDR_W:0] c_CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

    assign w_final  = (r_cnt == c_CNT_LAST);
    assign w_sum_ok = 1'b1;
    assign w_we     = w_accept;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_table_valid <= 1'b0;
            r_load_err    <= 1'b0;
            r_load_done   <= 1'b0;
`ifdef PWL_CHECKSUM_EN
            r_xor         <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_table_valid <= w_table_valid_nxt;
            r_load_err    <= w_load_err_nxt;
            r_load_done   <= w_load_done_nxt;
`ifdef PWL_CHECKSUM_EN
            r_xor         <= w_xor_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_table_valid_nxt = r_table_valid;
        w_load_err_nxt    = r_load_err;
        w_load_done_nxt   = 1'b0;
`ifdef PWL_CHECKSUM_EN
        w_xor_nxt         = r_xor;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt       = ST_LOAD;
                    w_cnt_nxt         = '0;
                    w_table_valid_nxt = 1'b0;
                    w_load_err_nxt    = 1'b0;
`ifdef PWL_CHECKSUM_EN
                    w_xor_nxt         = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + 1'b1;
`ifdef PWL_CHECKSUM_EN
                    if (!w_final) begin
                        w_xor_nxt = r_xor ^ s_data;
                    end
`endif
                    if (w_final) begin
                        w_state_nxt = ST_IDLE;
                        if (s_last && w_sum_ok) begin
                            w_table_valid_nxt = 1'b1;
                            w_load_done_nxt   = 1'b1;
                        end else begin
                            w_load_err_nxt    = 1'b1;
                        end
                    end else if (s_last) begin
                        // Short load: the word is kept but the table is not
                        // trusted.
                        w_state_nxt    = ST_IDLE;
                        w_load_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    pwl_coeff_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_we),
        .i_wr_addr (r_cnt[ADDR_W-1:0]),
        .i_wr_data (s_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    assign s_ready     = (r_state == ST_LOAD);
    assign table_valid = r_table_valid;
    assign load_done   = r_load_done;
    assign load_err    = r_load_err;

endmodule : pwl_coeff_loader
`default_nettype wire

// File: tb/tb_pwl_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwl_coeff_loader
// Description : Directed self-checking bench for pwl_coeff_loader.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pwl_coeff_loader;

`ifdef PWL_CHECKSUM_EN
    localparam int c_CK = 1;
`else
    localparam int c_CK = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        table_valid;
    logic        load_done;
    logic        load_err;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int ncyc    = 0;
    int done_cnt = 0;

    pwl_coeff_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .table_valid (table_valid),
        .load_done   (load_done),
        .load_err    (load_err),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [15:0] sb, input int i);
        return {sb + i[15:0], i[15:0]};
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ncyc = 0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge clk); ncyc++; #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle1();
        @(posedge clk); ncyc++; #1;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        rd_addr = a;
        @(posedge clk); #1;
        d = rd_data;
    endtask

    // Full load; with the checksum option the XOR word follows, bit 0
    // flipped when bad is set.
    task automatic load_full(input logic [15:0] sb, input bit gap, input bit bad);
        logic [31:0] x;
        x = '0;
        do_start();
        for (int i = 0; i < 64; i++) begin
            x = x ^ wd(sb, i);
            send(wd(sb, i), (c_CK == 0) && (i == 63));
            if (gap && ((i < 63) || (c_CK == 1))) idle1();
        end
        if (c_CK == 1) send(x ^ {31'd0, bad}, 1'b1);
    endtask

    initial begin
        logic [31:0] d;
        int d0;
        rst_n = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; rd_addr = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready",     {31'd0, s_ready},     32'd0);
        chk("rst_table_valid", {31'd0, table_valid}, 32'd0);
        chk("rst_load_done",   {31'd0, load_done},   32'd0);
        chk("rst_load_err",    {31'd0, load_err},    32'd0);
        chk("rst_rd_data",     rd_data,              32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back full load
        d0 = done_cnt;
        load_full(16'h1000, 1'b0, 1'b0);
        @(negedge clk);
        chk("l1_done",  {31'd0, load_done},   32'd1);
        chk("l1_valid", {31'd0, table_valid}, 32'd1);
        chk("l1_ready", {31'd0, s_ready},     32'd0);
        chk("l1_cycles", ncyc, 64 + c_CK);
        @(posedge clk); #1;
        chk("l1_done_drop", {31'd0, load_done}, 32'd0);
        chk("l1_done_once", done_cnt - d0, 32'd1);
        rd(6'd5, d);  chk("l1_rd5",  d, 32'h1005_0005);
        rd(6'd0, d);  chk("l1_rd0",  d, 32'h1000_0000);
        rd(6'd63, d); chk("l1_rd63", d, 32'h103F_003F);

        // Early s_last on word 10
        do_start();
        chk("start_ready", {31'd0, s_ready}, 32'd1);
        chk("start_clr_valid", {31'd0, table_valid}, 32'd0);
        for (int i = 0; i <= 10; i++) send(wd(16'h3000, i), i == 10);
        @(negedge clk);
        chk("el_err",   {31'd0, load_err},    32'd1);
        chk("el_valid", {31'd0, table_valid}, 32'd0);
        chk("el_ready", {31'd0, s_ready},     32'd0);
        chk("el_done",  {31'd0, load_done},   32'd0);
        @(posedge clk); #1;
        chk("el_ready2", {31'd0, s_ready}, 32'd0);
        rd(6'd10, d); chk("el_rd10", d, 32'h300A_000A);
        do_start();
        chk("el_err_clr", {31'd0, load_err}, 32'd0);
        chk("el_ready3",  {31'd0, s_ready},  32'd1);

        // Reset mid-load after 30 words (0..29)
        for (int i = 0; i < 30; i++) send(wd(16'h4000, i), 1'b0);
        rst_n = 1'b0;
        #2;
        chk("mr_ready", {31'd0, s_ready},     32'd0);
        chk("mr_valid", {31'd0, table_valid}, 32'd0);
        chk("mr_err",   {31'd0, load_err},    32'd0);
        chk("mr_done",  {31'd0, load_done},   32'd0);
        chk("mr_rd",    rd_data,              32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        rd(6'd0, d);  chk("mr_rd0",  d, 32'h4000_0000);
        rd(6'd29, d); chk("mr_rd29", d, 32'h401D_001D);
        chk("mr_ready2", {31'd0, s_ready}, 32'd0);

        // Load with s_valid toggling every other cycle
        d0 = done_cnt;
        load_full(16'h1000, 1'b1, 1'b0);
        @(negedge clk);
        chk("gp_done",   {31'd0, load_done},   32'd1);
        chk("gp_valid",  {31'd0, table_valid}, 32'd1);
        chk("gp_cycles", ncyc, 127 + 2 * c_CK);
        rd(6'd5, d);  chk("gp_rd5",  d, 32'h1005_0005);
        rd(6'd10, d); chk("gp_rd10", d, 32'h100A_000A);
        rd(6'd29, d); chk("gp_rd29", d, 32'h101D_001D);
        chk("gp_done_once", done_cnt - d0, 32'd1);

        // Read-before-write on address 7
        begin
            logic [31:0] x;
            x = '0;
            do_start();
            rd_addr = 6'd7;
            for (int i = 0; i < 64; i++) begin
                x = x ^ wd(16'h5000, i);
                send(wd(16'h5000, i), (c_CK == 0) && (i == 63));
                if (i == 7) chk("rbw_old", rd_data, 32'h1007_0007);
                if (i == 8) chk("rbw_new", rd_data, 32'h5007_0007);
            end
            if (c_CK == 1) send(x, 1'b1);
            @(negedge clk);
            chk("rbw_valid", {31'd0, table_valid}, 32'd1);
        end

`ifdef PWL_CHECKSUM_EN
        load_full(16'h6000, 1'b0, 1'b1);
        @(negedge clk);
        chk("ck_bad_err",   {31'd0, load_err},    32'd1);
        chk("ck_bad_valid", {31'd0, table_valid}, 32'd0);
        @(posedge clk); #1;
        load_full(16'h6000, 1'b0, 1'b0);
        @(negedge clk);
        chk("ck_ok_valid", {31'd0, table_valid}, 32'd1);
        chk("ck_ok_err",   {31'd0, load_err},    32'd0);
        @(posedge clk); #1;
        rd(6'd63, d); chk("ck_rd63", d, 32'h603F_003F);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pwl_coeff_loader
`default_nettype wire

// File: doc/pwl_coeff_loader.md
# pwl_coeff_loader

Writer side of the PWL activation coefficient tables. It accepts a valid/ready stream of packed coefficient words `{slope[15:0], intercept[15:0]}`, both Q3.12, and writes them in address order into a writable 64-entry table. It also provides the registered read port that the PWL evaluator indexes with `in_data[15:10]`. This lets softplus and other PWL tables be reloaded at run time instead of being fixed by `$readmemh`.

## Interface
- `DEPTH`, 64: table entries; must be a power of two.
- `ADDR_W`, 6: log2(DEPTH).
- `WORD_W`, 32: packed coefficient width, `{slope, intercept}`.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a table load.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  WORD_W  coefficient word (or checksum word, see Configuration).
- `s_last`  in  1  marks the final word of the load.
- `table_valid`  out  1  table holds a complete, accepted load.
- `load_done`  out  1  one-cycle pulse when a load completes successfully.
- `load_err`  out  1  sticky error flag; cleared by the next `start`.
- `rd_addr`  in  ADDR_W  evaluator read address.
- `rd_data`  out  WORD_W  registered read data.

## Operation
- States:
  - IDLE: `s_ready` = 0. On `start`, go to LOAD and clear the word counter `cnt`, `table_valid` and `load_err`.
  - LOAD: `s_ready` = 1. `start` is ignored.
- Accepted word: `s_valid && s_ready` writes `s_data` to `table[cnt]` and increments `cnt`.
- Final word: the word with `cnt == DEPTH-1`, or the checksum word when `PWL_CHECKSUM_EN` is defined.
- On the final word, the loader always returns to IDLE:
  - If `s_last` = 1 and the checksum passes (when enabled): `table_valid` <= 1 and `load_done` pulses for one cycle.
  - Otherwise: `load_err` <= 1 and `table_valid` stays 0.
- Early `s_last` on a non-final word: the word is written, `load_err` <= 1, `table_valid` stays 0, and the loader returns to IDLE.
- `cnt` never wraps. A load ends at the final word; any further stream words see `s_ready` = 0.
- Read port:
  - `rd_data <= table[rd_addr]` every cycle, independent of state.
  - Same-cycle write and read of the same address returns the old contents (read-before-write).
  - Reads during LOAD return partially written contents. The evaluator must gate on `table_valid`.
- Reset:
  - Asserting `rst_n` in any state, including mid-load, forces IDLE.
  - Reset values: `s_ready` = 0, `table_valid` = 0, `load_done` = 0, `load_err` = 0, `rd_data` = 0, `cnt` = 0.
  - Table contents are not cleared by reset.

## Timing
- Write latency: 1 cycle from the accept edge. The written data is visible on `rd_data` two edges after acceptance when `rd_addr` matches.
- Read latency: 1 cycle.
- Throughput: one word per cycle while `s_valid` is held high. A 64-word load completes in 64 cycles after the cycle in which LOAD is entered.
- `start` to `s_ready` = 1: 1 cycle.
- `load_done` and `table_valid` rise on the edge that accepts the final word.
- `s_ready` drops on that same edge.

## Configuration
- `PWL_CHECKSUM_EN` defined:
  - The load is 65 words: 64 coefficient words, then one checksum word.
  - The checksum word must equal the XOR of all 64 coefficient words and must carry `s_last`.
  - The checksum word is not written to the table.
  - On mismatch: `load_err` <= 1 and `table_valid` stays 0.
- `PWL_CHECKSUM_EN` undefined:
  - The load is 64 words, with `s_last` on word 63.
  - No XOR accumulator is built.

## Structure
- Shared package holds `DATA_WIDTH`, `FRAC_BITS`, `PWL_DEPTH`, `PWL_ADDR_W`, and the packed coefficient word typedef (`slope`, `intercept` fields).
- One sub-module, `pwl_coeff_ram`: a 1-write, 1-read synchronous RAM with read-before-write behaviour, `(* ram_style = "distributed" *)`.
- The FSM, word counter and checksum accumulator stay in `pwl_coeff_loader`.

## Test plan
- Reset, `start`, then 64 words `s_data = {16'h1000 + i, 16'h0000 + i}` with `s_last` on i = 63:
  - `load_done` pulses once and `table_valid` = 1.
  - `rd_addr = 6'd5` gives `rd_data = 32'h1005_0005` one cycle later.
- Same load with `s_valid` toggling every other cycle:
  - Identical table contents.
  - Completion occurs 127 cycles after `s_ready` rises.
- `s_last` asserted on word 10:
  - `load_err` = 1, `table_valid` = 0, `s_ready` = 0 from the next cycle.
  - A following `start` clears `load_err`.
- `rst_n` pulsed low after word 30:
  - All outputs at reset values and `s_ready` = 0.
  - `table[0..29]` still readable with the loaded values.
- Read and write of address 7 in the same cycle: `rd_data` returns the pre-write value; the next read returns the new value.
- With `PWL_CHECKSUM_EN`:
  - Correct XOR word: `table_valid` = 1.
  - XOR word with bit 0 flipped: `load_err` = 1 and `table_valid` = 0.
